// File: rtl/silife_gen_scheduler_pkg.sv
// Shared definitions for the SiLife generation scheduler: register map,
// CTRL/STATUS bit positions and the step handshake FSM states.
package silife_sched_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_GEN    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_STEP = 1;
    localparam int CTRL_GCLR = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_PEND = 1;
    localparam int STAT_RUN  = 2;
    localparam int STAT_EXT  = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/silife_gen_scheduler_prescaler.sv
// Loadable down-counter: ticks when enabled at zero and reloads, holds when disabled.
module silife_prescaler #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign tick = en && !load && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? load_val : cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/silife_gen_scheduler.sv
// Wishbone-controlled generation scheduler: free-running or single-step req/ack with the grid.
// Optional external step input enabled by defining SILIFE_SCHED_EXT_TRIG_EN.
module silife_gen_scheduler
    import silife_sched_pkg::*;
#(
    parameter int PERIOD_BITS = 24,
    parameter int GEN_BITS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_step_req,
    input  logic        i_step_ack,
`ifdef SILIFE_SCHED_EXT_TRIG_EN
    input  logic        i_ext_step,
`endif
    output logic        o_busy
);

    logic                   ack_q, ack_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   run_q, run_d;
    logic                   pend_q, pend_d;
    logic [PERIOD_BITS-1:0] period_q, period_d;
    logic [GEN_BITS-1:0]    gen_q, gen_d;
    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   busy_q, busy_d;

    logic                   wr_en, wr_ctrl, step_set, launch, done;
    logic                   presc_en, presc_load, tick;
    logic [PERIOD_BITS-1:0] reload_val;
    logic [1:0]             addr;
    logic [31:0]            rd;
    logic                   ext_edge, ext_lvl;
    logic                   unused_bits;

    assign unused_bits = ^{i_wb_addr[31:4], i_wb_addr[1:0], i_wb_data};

`ifdef SILIFE_SCHED_EXT_TRIG_EN
    logic sync1_q, sync2_q, ext_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            ext_prev_q <= 1'b0;
        end else begin
            sync1_q    <= i_ext_step;
            sync2_q    <= sync1_q;
            ext_prev_q <= sync2_q;
        end
    end

    assign ext_edge = sync2_q && !ext_prev_q;
    assign ext_lvl  = sync2_q;
`else
    assign ext_edge = 1'b0;
    assign ext_lvl  = 1'b0;
`endif

    assign addr       = i_wb_addr[3:2];
    assign ack_d      = i_wb_stb && i_wb_cyc && !ack_q;
    assign wr_en      = ack_d && i_wb_we;
    assign wr_ctrl    = wr_en && (addr == REG_CTRL);
    assign step_set   = (wr_ctrl && i_wb_data[CTRL_STEP]) || ext_edge;
    // PERIOD=0 is treated as PERIOD=1, so the reload never underflows
    assign reload_val = (period_q == '0) ? '0 : period_q - PERIOD_BITS'(1);
    assign presc_en   = run_q && (state_q == S_IDLE);
    assign presc_load = wr_ctrl && i_wb_data[CTRL_RUN] && !run_q;

    silife_prescaler #(
        .WIDTH (PERIOD_BITS)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (presc_en),
        .load     (presc_load),
        .load_val (reload_val),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        busy_d  = busy_q;
        launch  = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick || pend_q) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    launch  = 1'b1;
                end
            end
            S_REQ: begin
                if (i_step_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    done    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run_d    = run_q;
        period_d = period_q;
        pend_d   = pend_q;
        gen_d    = gen_q;
        if (wr_ctrl) run_d = i_wb_data[CTRL_RUN];
        if (wr_en && (addr == REG_PERIOD)) period_d = i_wb_data[PERIOD_BITS-1:0];
        // A step request arriving on the launch edge queues one more step
        if (launch) pend_d = 1'b0;
        if (step_set) pend_d = 1'b1;
        if (done) gen_d = gen_q + GEN_BITS'(1);
        if (wr_ctrl && i_wb_data[CTRL_GCLR]) gen_d = '0;
    end

    always_comb begin
        rd = '0;
        case (addr)
            REG_CTRL:   rd[CTRL_RUN] = run_q;
            REG_PERIOD: rd[PERIOD_BITS-1:0] = period_q;
            REG_GEN:    rd[GEN_BITS-1:0] = gen_q;
            default: begin
                rd[STAT_BUSY] = busy_q;
                rd[STAT_PEND] = pend_q;
                rd[STAT_RUN]  = run_q;
                rd[STAT_EXT]  = ext_lvl;
            end
        endcase
        rdata_d = ack_d ? rd : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            run_q    <= 1'b0;
            pend_q   <= 1'b0;
            period_q <= '0;
            gen_q    <= '0;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            run_q    <= run_d;
            pend_q   <= pend_d;
            period_q <= period_d;
            gen_q    <= gen_d;
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_step_req = req_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_silife_gen_scheduler.sv
// Scoreboard bench for silife_gen_scheduler: reads push expected values, a monitor pops on ack.
module tb_silife_gen_scheduler;
    import silife_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;
    logic        o_step_req, i_step_ack, o_busy;
`ifdef SILIFE_SCHED_EXT_TRIG_EN
    logic        i_ext_step;
`endif

    silife_gen_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_ack   (o_wb_ack),
        .o_wb_data  (o_wb_data),
        .o_step_req (o_step_req),
        .i_step_ack (i_step_ack),
`ifdef SILIFE_SCHED_EXT_TRIG_EN
        .i_ext_step (i_ext_step),
`endif
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t  exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    rises = 0;
    int    rise_t[$];
    logic  req_prev = 1'b0;
    int    ack_dly = 3;
    bit    grid_auto = 1'b1;
    int    base;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: counts request rising edges and scores every read ack
    always @(negedge clk) begin
        if (o_step_req && !req_prev) begin
            rises++;
            rise_t.push_back(cyc);
        end
        req_prev = o_step_req;
        if (o_wb_ack && !i_wb_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read_ack: got data 0x%08h with nothing expected", o_wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, o_wb_data, e.val);
            end
        end
    end

    // Grid model: acknowledges each request ack_dly cycles after seeing it
    initial begin
        i_step_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (grid_auto && o_step_req && !reset) begin
                repeat (ack_dly) @(posedge clk);
                #1;
                i_step_ack = 1'b1;
                @(posedge clk);
                #1;
                i_step_ack = 1'b0;
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [1:0] reg_idx, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = {28'h0, reg_idx, 2'b00};
        i_wb_data = wdata;
        @(posedge clk);
        #1;
        check("ack_latency", {31'h0, o_wb_ack}, 32'h1);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] reg_idx, input logic [31:0] wdata);
        wb_xfer(1'b1, reg_idx, wdata);
    endtask

    task automatic wb_read(input logic [1:0] reg_idx, input string name, input logic [31:0] expv);
        exp_t e;
        e.name = name;
        e.val  = expv;
        exp_q.push_back(e);
        wb_xfer(1'b0, reg_idx, 32'h0);
    endtask

    task automatic wait_rises(input int n, input int lim);
        int i = 0;
        while (rises < n && i < lim) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("wait_rises_timeout", (rises >= n) ? 32'h1 : 32'h0, 32'h1);
    endtask

    task automatic wait_idle(input int lim);
        int i = 0;
        while (o_busy && i < lim) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("wait_idle_timeout", {31'h0, o_busy}, 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_addr = 32'h0;
        i_wb_data = 32'h0;
`ifdef SILIFE_SCHED_EXT_TRIG_EN
        i_ext_step = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_step_req", {31'h0, o_step_req}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        check("rst_wb_ack", {31'h0, o_wb_ack}, 32'h0);
        check("rst_wb_data", o_wb_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        wb_read(REG_CTRL, "rst_ctrl", 32'h0);
        wb_read(REG_PERIOD, "rst_period", 32'h0);
        wb_read(REG_GEN, "rst_gen", 32'h0);
        wb_read(REG_STATUS, "rst_status", 32'h0);

        // Single software step
        base    = rises;
        ack_dly = 3;
        wb_write(REG_CTRL, 32'h2);
        wb_read(REG_STATUS, "status_busy_in_req", 32'h1);
        wait_idle(50);
        repeat (5) @(negedge clk);
        #1;
        check("single_step_count", rises - base, 32'd1);
        wb_read(REG_GEN, "gen_after_step", 32'h1);
        wb_read(REG_CTRL, "ctrl_step_self_clear", 32'h0);

        // Free-running at PERIOD=4
        wb_write(REG_CTRL, 32'h4);
        wb_read(REG_GEN, "gen_cleared", 32'h0);
        wb_write(REG_PERIOD, 32'h4);
        wb_read(REG_PERIOD, "period_rw", 32'h4);
        ack_dly = 1;
        base    = rises;
        wb_write(REG_CTRL, 32'h1);
        wait_rises(base + 4, 100);
        wait_idle(20);
        ack_dly = 6;
        wait_rises(base + 5, 50);
        wb_write(REG_CTRL, 32'h0);
        wait_idle(50);
        repeat (20) @(negedge clk);
        #1;
        check("run_stop_count", rises - base, 32'd5);
        for (int k = 1; k < 5; k++) begin
            if (rise_t.size() > base + k)
                check("period_spacing", rise_t[base + k] - rise_t[base + k - 1], 32'd6);
            else
                check("period_spacing_missing", rise_t.size(), base + k + 1);
        end
        wb_read(REG_GEN, "gen_after_run", 32'h5);
        wb_read(REG_STATUS, "status_stopped", 32'h0);

        // Multiple step writes during one request collapse to one pending step
        ack_dly = 10;
        wb_write(REG_CTRL, 32'h4);
        wb_read(REG_GEN, "gen_cleared2", 32'h0);
        base = rises;
        wb_write(REG_CTRL, 32'h2);
        wb_write(REG_CTRL, 32'h2);
        wb_write(REG_CTRL, 32'h2);
        wb_write(REG_CTRL, 32'h2);
        wb_read(REG_STATUS, "status_busy_pending", 32'h3);
        wait_rises(base + 2, 100);
        wait_idle(50);
        repeat (10) @(negedge clk);
        #1;
        check("collapse_count", rises - base, 32'd2);
        wb_read(REG_GEN, "gen_after_collapse", 32'h2);

        // Generation counter wrap
        ack_dly = 1;
        @(posedge clk);
        #1;
        force dut.gen_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.gen_q;
        wb_read(REG_GEN, "gen_preload", 32'hFFFF_FFFF);
        base = rises;
        wb_write(REG_CTRL, 32'h2);
        wait_rises(base + 1, 20);
        wait_idle(20);
        wb_read(REG_GEN, "gen_wrap", 32'h0);

        // gen_clear on the same edge as the grid ack
        grid_auto = 1'b0;
        base      = rises;
        wb_write(REG_CTRL, 32'h2);
        wait_rises(base + 1, 20);
        repeat (2) @(posedge clk);
        fork
            wb_write(REG_CTRL, 32'h4);
            begin
                @(posedge clk);
                #1;
                i_step_ack = 1'b1;
                @(posedge clk);
                #1;
                i_step_ack = 1'b0;
            end
        join
        check("req_dropped_on_ack", {31'h0, o_step_req}, 32'h0);
        wb_read(REG_GEN, "gen_clear_wins", 32'h0);

        // Ack while idle is ignored
        @(posedge clk);
        #1;
        i_step_ack = 1'b1;
        @(posedge clk);
        #1;
        i_step_ack = 1'b0;
        wb_read(REG_GEN, "gen_idle_ack_ignored", 32'h0);
        check("idle_ack_no_req", {31'h0, o_step_req}, 32'h0);

        // Asynchronous reset in the middle of a step
        base = rises;
        wb_write(REG_CTRL, 32'h2);
        wait_rises(base + 1, 20);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_req", {31'h0, o_step_req}, 32'h0);
        check("async_rst_busy", {31'h0, o_busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wb_read(REG_GEN, "gen_after_reset", 32'h0);
        wb_read(REG_PERIOD, "period_after_reset", 32'h0);
        wb_read(REG_STATUS, "status_after_reset", 32'h0);

`ifdef SILIFE_SCHED_EXT_TRIG_EN
        // External trigger held high yields exactly one step
        grid_auto = 1'b1;
        ack_dly   = 2;
        base      = rises;
        @(posedge clk);
        #1;
        i_ext_step = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        wb_read(REG_STATUS, "status_ext_level", 32'h8);
        i_ext_step = 1'b0;
        wait_idle(20);
        repeat (10) @(negedge clk);
        #1;
        check("ext_step_count", rises - base, 32'd1);
        wb_read(REG_GEN, "gen_after_ext", 32'h1);
`endif

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
